instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 stall_d  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 flush_d  input  1  kill the instruction currently in the IF/ID register.
REQ-006 branch_taken  input  1  one-cycle redirect request.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_ready  input  1  memory completes the request this cycle.
REQ-011 imem_rdata  input  32  instruction word; valid only when imem_ready=1.
REQ-012 instr_d  output  32  IF/ID instruction.
REQ-013 pcplus4_d  output  32  IF/ID PC+4 of instr_d.
REQ-014 valid_d  output  1  instr_d holds a live instruction.
REQ-015 misalign  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-016 Handshake: imem_addr SHALL stay stable while imem_req=1 and imem_ready=0; the transfer completes on the cycle where both are 1.
REQ-017 FSM states SHALL be RUN, BUF and DROP.
REQ-018 RUN: imem_req=1 and imem_addr=pc.
- On completion with stall_d=0: instr_d<=imem_rdata, pcplus4_d<=pc+4, valid_d<=1, pc<=pc+4; stay in RUN.
- On completion with stall_d=1: capture word and pc+4 into the skid buffer; go to BUF.
- With no completion and stall_d=0: valid_d<=0.
REQ-019 BUF: imem_req=0 and IF/ID holds. When stall_d=0, move the buffer into IF/ID with valid_d<=1, pc<=pc+4, and return to RUN.
REQ-020 DROP: imem_req=1 at the old address. The completing word SHALL be discarded; then pc<=held target, state<=RUN, and no IF/ID update occurs.
REQ-021 Redirect when branch_taken=1:
- In RUN with completion, or in BUF: pc<=target and state<=RUN; any buffered word is discarded.
- In RUN without completion: hold the target, go to DROP.
- In DROP: replace the held target (newest wins).
REQ-022 A redirect SHALL set valid_d<=0 and instr_d<=32'h0 on that edge, regardless of stall_d.
REQ-023 Targets SHALL be forced word-aligned (bits [1:0]<=0); misalign<=1 if target[1:0]!=0, cleared only by reset.
REQ-024 flush_d=1 with no redirect: valid_d<=0 and instr_d<=0; a word completing that same cycle with stall_d=0 loads IF/ID instead (new fetch beats flush).
REQ-025 Priority SHALL be reset > branch_taken > flush_d > stall_d.
REQ-026 stall_d=1 with no flush or redirect SHALL hold instr_d, pcplus4_d and valid_d unchanged.
REQ-027 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
REQ-028 Fetch latency: an instruction reaches IF/ID on the edge that ends its completing cycle (one register stage, zero wait-state minimum).

Reset
REQ-029 While rst_n=0 at an edge:
- pc<=RESET_PC, state<=RUN, instr_d<=0, pcplus4_d<=0, valid_d<=0, misalign<=0, and the skid buffer is emptied.
- imem_req SHALL be 0 during any cycle where rst_n=0.
REQ-030 Reset mid-transfer, including in DROP or BUF, SHALL abandon the transfer; the first post-reset request SHALL be at RESET_PC.

Verification
REQ-031 Reset release, imem_ready always 1, rdata=addr ^ 32'hA5A5_0000 -> imem_addr=0,4,8 on successive cycles; instr_d=32'hA5A5_0000 with pcplus4_d=4 one edge after the first fetch.
REQ-032 imem_ready low 3 cycles at addr 0x10 -> imem_addr held at 0x10 and valid_d=0 for those cycles; the word appears in instr_d after the ready cycle.
REQ-033 stall_d high 2 cycles while the word at 0x20 completes -> state BUF, imem_req=0, IF/ID unchanged; after release instr_d=word(0x20) and the next request is at 0x24.
REQ-034 branch_taken, target=0x103 while the 0x40 request waits 2 cycles -> word(0x40) discarded, next imem_addr=0x100, misalign=1, valid_d=0 after the redirect edge.
REQ-035 branch_taken and flush_d together with stall_d=1 -> valid_d=0, instr_d=0, pc=target; pc=32'hFFFF_FFFC completion -> next addr 0.
REQ-036 rst_n low for one edge while in BUF -> imem_req=0 that cycle, then a request at RESET_PC with valid_d=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction memory handshake and loads the IF/ID register.
// A one-entry skid buffer absorbs a word that completes while decode is stalled.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        misalign
);

  typedef enum logic [1:0] {StRun, StBuf, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic        misalign_q, misalign_d;

  logic        req_int;
  logic        done;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;

  // BUF is the only state without an outstanding request.
  assign req_int  = (state_q != StBuf);
  assign done     = req_int && imem_ready;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = {branch_target[31:2], 2'b00};

  assign imem_req  = rst_n && req_int;
  assign imem_addr = pc_q;
  assign instr_d   = if_instr_q;
  assign pcplus4_d = if_pc4_q;
  assign valid_d   = if_valid_q;
  assign misalign  = misalign_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    if_instr_d  = if_instr_q;
    if_pc4_d    = if_pc4_q;
    if_valid_d  = if_valid_q;
    misalign_d  = misalign_q;

    if (branch_taken) begin
      misalign_d = misalign_q | (|branch_target[1:0]);
      if_valid_d = 1'b0;
      if_instr_d = 32'h0;
      unique case (state_q)
        StRun: begin
          if (done) begin
            pc_d = br_tgt;
          end else begin
            // The in-flight request cannot be withdrawn; let it finish, then discard it.
            tgt_d   = br_tgt;
            state_d = StDrop;
          end
        end
        StBuf: begin
          pc_d    = br_tgt;
          state_d = StRun;
        end
        StDrop: begin
          if (done) begin
            pc_d    = br_tgt;
            state_d = StRun;
          end else begin
            tgt_d = br_tgt;
          end
        end
        default: state_d = StRun;
      endcase
    end else begin
      if (flush_d) begin
        if_valid_d = 1'b0;
        if_instr_d = 32'h0;
      end
      unique case (state_q)
        StRun: begin
          if (done) begin
            if (!stall_d) begin
              if_instr_d = imem_rdata;
              if_pc4_d   = pc_plus4;
              if_valid_d = 1'b1;
              pc_d       = pc_plus4;
            end else begin
              buf_instr_d = imem_rdata;
              state_d     = StBuf;
            end
          end else if (!stall_d) begin
            if_valid_d = 1'b0;
          end
        end
        StBuf: begin
          // pc_q still points at the buffered word, so pc_plus4 is its PC+4.
          if (!stall_d) begin
            if_instr_d = buf_instr_q;
            if_pc4_d   = pc_plus4;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = StRun;
          end
        end
        StDrop: begin
          if (done) begin
            pc_d    = tgt_q;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      tgt_q       <= 32'h0;
      buf_instr_q <= 32'h0;
      if_instr_q  <= 32'h0;
      if_pc4_q    <= 32'h0;
      if_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      if_instr_q  <= if_instr_d;
      if_pc4_q    <= if_pc4_d;
      if_valid_q  <= if_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ready) |=> $stable(imem_addr));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences plus a cycle-level reference model
// compared against the DUT on every negative clock edge.
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall_d, flush_d, branch_taken, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, instr_d, pcplus4_d;
  logic        valid_d, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory returns addr ^ K; garbage when not ready, so capturing it early is visible.
  assign imem_rdata = imem_ready ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_d      (instr_d),
    .pcplus4_d    (pcplus4_d),
    .valid_d      (valid_d),
    .misalign     (misalign)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, a pending skid word, and a pending redirect.
  bit          m_init = 0;
  logic [31:0] m_pc, m_buf, m_tgt, m_instr, m_pc4;
  bit          m_buffered, m_dropping, m_valid, m_mis;

  always @(posedge clk) begin
    bit          req, fin;
    logic [31:0] t;
    if (!rst_n) begin
      m_init = 1; m_pc = 32'h0; m_buf = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_buffered = 0; m_dropping = 0; m_valid = 0; m_mis = 0;
    end else if (m_init) begin
      req = !m_buffered;
      fin = req && imem_ready;
      if (branch_taken) begin
        t = branch_target & 32'hFFFF_FFFC;
        if (branch_target[1:0] != 2'b00) m_mis = 1;
        m_valid = 0; m_instr = 32'h0;
        if (m_buffered) begin
          m_buffered = 0; m_pc = t;
        end else if (fin) begin
          m_dropping = 0; m_pc = t;
        end else begin
          m_dropping = 1; m_tgt = t;
        end
      end else begin
        if (flush_d) begin
          m_valid = 0; m_instr = 32'h0;
        end
        if (m_dropping) begin
          if (fin) begin
            m_pc = m_tgt; m_dropping = 0;
          end
        end else if (m_buffered) begin
          if (!stall_d) begin
            m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_buffered = 0;
          end
        end else if (fin) begin
          if (!stall_d) begin
            m_instr = m_pc ^ K; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
          end else begin
            m_buf = m_pc ^ K; m_buffered = 1;
          end
        end else if (!stall_d) begin
          m_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("req", {31'b0, imem_req}, {31'b0, rst_n && !m_buffered});
      if (rst_n && !m_buffered) check("addr", imem_addr, m_pc);
      check("instr", instr_d, m_instr);
      check("pcplus4", pcplus4_d, m_pc4);
      check("valid", {31'b0, valid_d}, {31'b0, m_valid});
      check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; stall_d = 0; flush_d = 0; branch_taken = 0; branch_target = 32'h0;
    imem_ready = 1;
    tick(); tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, valid_d}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);

    // Zero-wait streaming from RESET_PC
    rst_n = 1;
    #1;
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("first_instr", instr_d, 32'hA5A5_0000);
    check("first_pc4", pcplus4_d, 32'h4);
    check("second_addr", imem_addr, 32'h4);
    tick();
    check("third_addr", imem_addr, 32'h8);
    tick(); tick();

    // Wait states at 0x10
    check("wait_addr0", imem_addr, 32'h10);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_addr", imem_addr, 32'h10);
      check("wait_valid", {31'b0, valid_d}, 32'd0);
    end
    imem_ready = 1;
    tick();
    check("wait_instr", instr_d, 32'hA5A5_0010);
    tick(); tick(); tick();

    // Stall while 0x20 completes
    check("stall_addr", imem_addr, 32'h20);
    stall_d = 1;
    tick();
    check("buf_req", {31'b0, imem_req}, 32'd0);
    check("buf_hold", instr_d, 32'hA5A5_001C);
    tick();
    check("buf_hold2", instr_d, 32'hA5A5_001C);
    stall_d = 0;
    tick();
    check("buf_instr", instr_d, 32'hA5A5_0020);
    check("buf_pc4", pcplus4_d, 32'h24);
    check("buf_next", imem_addr, 32'h24);

    // Redirect while 0x40 waits
    repeat (7) tick();
    check("br_addr0", imem_addr, 32'h40);
    imem_ready = 0;
    tick();
    branch_taken = 1; branch_target = 32'h103;
    tick();
    branch_taken = 0;
    check("br_valid", {31'b0, valid_d}, 32'd0);
    check("br_misalign", {31'b0, misalign}, 32'd1);
    check("br_hold", imem_addr, 32'h40);
    tick();
    imem_ready = 1;
    tick();
    check("br_target", imem_addr, 32'h100);
    check("br_drop", {31'b0, valid_d}, 32'd0);
    tick();
    check("br_instr", instr_d, 32'hA5A5_0100);

    // Redirect + flush + stall together, then PC wrap
    branch_taken = 1; flush_d = 1; stall_d = 1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 0; flush_d = 0; stall_d = 0;
    check("bfs_valid", {31'b0, valid_d}, 32'd0);
    check("bfs_instr", instr_d, 32'h0);
    check("bfs_pc", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_instr", instr_d, 32'h5A5A_FFFC);
    check("wrap_pc4", pcplus4_d, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Flush alone, then flush beaten by a new fetch
    flush_d = 1; imem_ready = 0;
    tick();
    check("flush_valid", {31'b0, valid_d}, 32'd0);
    check("flush_instr", instr_d, 32'h0);
    imem_ready = 1;
    tick();
    flush_d = 0;
    check("flush_beat", instr_d, 32'hA5A5_0000);
    check("flush_beat_v", {31'b0, valid_d}, 32'd1);

    // Reset while in BUF
    stall_d = 1;
    tick();
    rst_n = 0;
    #1;
    check("rstbuf_req", {31'b0, imem_req}, 32'd0);
    stall_d = 0;
    tick();
    rst_n = 1;
    #1;
    check("rstbuf_req1", {31'b0, imem_req}, 32'd1);
    check("rstbuf_addr", imem_addr, 32'h0);
    check("rstbuf_valid", {31'b0, valid_d}, 32'd0);

    // Mixed directed pattern, checked by the model
    for (int i = 0; i < 90; i++) begin
      imem_ready    = (i % 3) != 1;
      stall_d       = ((i % 5) == 2) || ((i % 7) == 3);
      flush_d       = (i % 11) == 4;
      branch_taken  = ((i % 13) == 6) || ((i % 17) == 9);
      branch_target = 32'h200 + 32'(i * 12) + 32'(i % 4);
      rst_n         = (i != 50);
      tick();
    end
    rst_n = 1; stall_d = 0; flush_d = 0; branch_taken = 0; imem_ready = 1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
